crc_frame_tx: RTL and testbench

Downstream output stage of the serial receive chain. It takes each captured byte and its 4-bit CRC from the capture/CRC stages and re-serialises them as a framed bitstream: sync pattern, data, then CRC, all MSB first. The frame format is compatible with the sequence detector on the input side, so the block can be looped back for self-test. It holds a one-deep pending slot, so a capture that arrives while a frame is still shifting out is not lost.

---
 rtl/crc_frame_tx_if.sv | 20 ++
 rtl/crc_frame_tx.sv | 152 +++++++++++++++
 tb/tb_crc_frame_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_tx_if.sv
// Capture-side inputs and serial-output signals of the CRC frame transmitter.
interface crc_frame_tx_if;
  logic       captured;
  logic [7:0] data;
  logic [3:0] crc;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       ovf;

  modport master (
    output captured, data, crc,
    input  tx, busy, frame_done, ovf
  );

  modport slave (
    input  captured, data, crc,
    output tx, busy, frame_done, ovf
  );
endinterface

// File: rtl/crc_frame_tx.sv
// Re-serialises captured {data, crc} as sync + data + CRC frames, MSB first, with a one-deep pending slot.
// Optional macro PARITY_EN appends an even-parity bit over {data, crc} to every frame.
module crc_frame_tx #(
  parameter int         SYNC_LEN     = 4,
  parameter logic [7:0] SYNC_PATTERN = 8'b0000_1101
) (
  input logic           clk,
  input logic           rst,
  crc_frame_tx_if.slave bus
);

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC, PAR} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC} state_t;
`endif

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);
  localparam logic [2:0] SYNC_TOP  = 3'(SYNC_LEN - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [11:0] shift_reg, shift_next;
  logic [11:0] pend_reg, pend_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        ovf_reg, ovf_next;
  logic        captured_q_reg;
  logic        tx_reg, busy_reg, done_reg;

  logic        accept;
  logic        last_bit;
  logic        bit_now;
  logic [11:0] word_in;
  logic [2:0]  sync_idx;

  assign word_in  = {bus.data, bus.crc};
  assign accept   = bus.captured & ~captured_q_reg;
  assign sync_idx = SYNC_TOP - cnt_reg[2:0];

`ifdef PARITY_EN
  assign last_bit = (state_reg == PAR);
`else
  assign last_bit = (state_reg == CRC) && (cnt_reg == 4'd3);
`endif

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + 4'd1;
    shift_next      = shift_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    ovf_next        = ovf_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (accept) begin
          state_next = SYNC;
          shift_next = word_in;
        end
      end
      SYNC: if (cnt_reg == SYNC_LAST) begin
        state_next = DATA;
        cnt_next   = '0;
      end
      DATA: if (cnt_reg == 4'd7) begin
        state_next = CRC;
        cnt_next   = '0;
      end
      CRC: begin
`ifdef PARITY_EN
        if (cnt_reg == 4'd3) begin
          state_next = PAR;
          cnt_next   = '0;
        end
`endif
      end
      default: state_next = state_reg;
    endcase

    // Frame end: chain the pending word (or a same-cycle accept) with no idle gap.
    if (last_bit) begin
      cnt_next = '0;
      if (pend_valid_reg) begin
        shift_next      = pend_reg;
        state_next      = SYNC;
        pend_valid_next = accept;
        if (accept) begin
          pend_next = word_in;
        end
      end else if (accept) begin
        shift_next = word_in;
        state_next = SYNC;
      end else begin
        state_next = IDLE;
      end
    end else if (accept && (state_reg != IDLE)) begin
      if (!pend_valid_reg) begin
        pend_next       = word_in;
        pend_valid_next = 1'b1;
      end else begin
        ovf_next = 1'b1;
      end
    end
  end

  always_comb begin
    bit_now = 1'b0;
    case (state_reg)
      SYNC:    bit_now = SYNC_PATTERN[sync_idx];
      DATA:    bit_now = shift_reg[4'd11 - cnt_reg];
      CRC:     bit_now = shift_reg[4'd3 - cnt_reg];
`ifdef PARITY_EN
      PAR:     bit_now = ^shift_reg;
`endif
      default: bit_now = 1'b0;
    endcase
  end

  // Output bits are registered, so tx trails the state/counter by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      ovf_reg        <= 1'b0;
      captured_q_reg <= 1'b0;
      tx_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      ovf_reg        <= ovf_next;
      captured_q_reg <= bus.captured;
      tx_reg         <= bit_now;
      busy_reg       <= (state_reg != IDLE);
      done_reg       <= last_bit;
    end
  end

  assign bus.tx         = tx_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = done_reg;
  assign bus.ovf        = ovf_reg;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Self-checking bench for crc_frame_tx: vector table plus scoreboard of expected serial bits.
module tb_crc_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;

  crc_frame_tx_if bus ();

  crc_frame_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef PARITY_EN
  localparam int F = 17;
`else
  localparam int F = 16;
`endif

  typedef struct {
    logic b;
    logic last;
    int   fid;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  crc;
    logic [15:0] frame;
  } vec_t;

  exp_t q[$];
  vec_t vecs[5];

  int errors   = 0;
  int checks   = 0;
  int run_len  = 0;
  int last_run = 0;
  int frames   = 0;
  int fid      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input vec_t v);
    exp_t e;
    for (int i = 15; i >= 0; i--) begin
      e.b    = v.frame[i];
`ifdef PARITY_EN
      e.last = 1'b0;
`else
      e.last = (i == 0);
`endif
      e.fid  = fid;
      q.push_back(e);
    end
`ifdef PARITY_EN
    e.b    = ^{v.data, v.crc};
    e.last = 1'b1;
    e.fid  = fid;
    q.push_back(e);
`endif
    $display("queued frame %0d: data=%02h crc=%01h", fid, v.data, v.crc);
    fid++;
  endtask

  // One clock of monitoring: compare the DUT's serial output against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.busy) begin
      if (q.size() == 0) begin
        chk("busy_without_frame", bus.busy, 1'b0);
      end else begin
        e = q.pop_front();
        chk($sformatf("tx_frame%0d", e.fid), bus.tx, e.b);
        chk($sformatf("frame_done_frame%0d", e.fid), bus.frame_done, e.last);
      end
      run_len++;
    end else begin
      chk("idle_tx", bus.tx, 1'b0);
      chk("idle_frame_done", bus.frame_done, 1'b0);
      if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
    if (bus.frame_done) frames++;
  endtask

  task automatic send(input vec_t v, input bit expect_sent);
    bus.captured = 1'b1;
    bus.data     = v.data;
    bus.crc      = v.crc;
    if (expect_sent) push_frame(v);
    tick();
    bus.captured = 1'b0;
    bus.data     = 8'($urandom);
    bus.crc      = 4'($urandom);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!bus.busy && q.size() == 0) return;
      tick();
    end
    chk("wait_idle_timeout", q.size(), 0);
    q.delete();
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, crc: 4'h3, frame: 16'hDA53};
    vecs[1] = '{data: 8'h3C, crc: 4'hE, frame: 16'hD3CE};
    vecs[2] = '{data: 8'h00, crc: 4'h0, frame: 16'hD000};
    vecs[3] = '{data: 8'hFF, crc: 4'hF, frame: 16'hDFFF};
    vecs[4] = '{data: 8'h81, crc: 4'h9, frame: 16'hD819};

    bus.captured = 1'b0;
    bus.data     = 8'h00;
    bus.crc      = 4'h0;

    repeat (3) tick();
    chk("reset_tx", bus.tx, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_frame_done", bus.frame_done, 1'b0);
    chk("reset_ovf", bus.ovf, 1'b0);
    rst = 1'b1;
    repeat (2) tick();

    // Single frame with first-bit latency.
    bus.captured = 1'b1;
    bus.data     = vecs[0].data;
    bus.crc      = vecs[0].crc;
    push_frame(vecs[0]);
    tick();
    chk("latency_busy_edge_n", bus.busy, 1'b0);
    bus.captured = 1'b0;
    bus.data     = 8'h5A;
    bus.crc      = 4'hC;
    tick();
    chk("latency_busy_edge_n1", bus.busy, 1'b1);
    wait_idle(60);
    chk("single_busy_len", last_run, F);
    chk("single_ovf", bus.ovf, 1'b0);

    for (int v = 1; v < 5; v++) begin
      send(vecs[v], 1'b1);
      wait_idle(60);
      chk($sformatf("table%0d_busy_len", v), last_run, F);
      repeat (2) tick();
    end

    // Held-high captured gives one frame only.
    begin
      int f0;
      f0 = frames;
      bus.captured = 1'b1;
      bus.data     = vecs[1].data;
      bus.crc      = vecs[1].crc;
      push_frame(vecs[1]);
      repeat (40) tick();
      bus.captured = 1'b0;
      wait_idle(60);
      chk("held_frame_count", frames - f0, 1);
      chk("held_ovf", bus.ovf, 1'b0);
    end
    repeat (2) tick();

    // Back-to-back via pending slot.
    send(vecs[0], 1'b1);
    repeat (4) tick();
    send(vecs[1], 1'b1);
    wait_idle(100);
    chk("b2b_busy_len", last_run, 2 * F);
    repeat (2) tick();

    // Bypass: accept exactly in the last-bit cycle with pending empty.
    send(vecs[2], 1'b1);
    repeat (F - 1) tick();
    send(vecs[3], 1'b1);
    wait_idle(100);
    chk("bypass_busy_len", last_run, 2 * F);
    chk("bypass_ovf", bus.ovf, 1'b0);
    repeat (2) tick();

    // Last-bit accept with pending full: new word takes the freed slot.
    send(vecs[0], 1'b1);
    repeat (3) tick();
    send(vecs[1], 1'b1);
    repeat (F - 5) tick();
    send(vecs[4], 1'b1);
    wait_idle(150);
    chk("lastbit_full_busy_len", last_run, 3 * F);
    chk("lastbit_full_ovf", bus.ovf, 1'b0);
    repeat (2) tick();

    // Overflow: third accept within one frame is dropped.
    send(vecs[0], 1'b1);
    repeat (2) tick();
    send(vecs[1], 1'b1);
    repeat (2) tick();
    send(vecs[2], 1'b0);
    wait_idle(150);
    chk("ovf_busy_len", last_run, 2 * F);
    chk("ovf_set", bus.ovf, 1'b1);
    repeat (10) tick();
    chk("ovf_sticky", bus.ovf, 1'b1);
    #2 rst = 1'b0;
    #1 chk("ovf_cleared_by_reset", bus.ovf, 1'b0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Reset mid-frame during DATA with pending full.
    send(vecs[0], 1'b1);
    repeat (2) tick();
    send(vecs[1], 1'b1);
    repeat (6) tick();
    chk("midreset_busy_before", bus.busy, 1'b1);
    q.delete();
    run_len = 0;
    #2 rst = 1'b0;
    #1;
    chk("midreset_tx", bus.tx, 1'b0);
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_frame_done", bus.frame_done, 1'b0);
    tick();
    rst = 1'b1;
    repeat (40) tick();
    chk("midreset_no_frame", last_run, 2 * F);
    send(vecs[3], 1'b1);
    wait_idle(60);
    chk("after_reset_busy_len", last_run, F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
